fnd_scan_ctrl: RTL
==================

# fnd_scan_ctrl

Four-digit time-multiplexed scan controller for the FND watch display. It sits directly upstream of the BCD-to-segment decoder and drives that decoder's 4-bit `bcd` input. It also drives the active-low digit commons, one digit at a time, with optional leading-zero blanking, anti-ghosting guard time and compile-time blink.

## Interface
- `SYS_CLK_HZ`, 100_000_000, system clock frequency.
- `SCAN_HZ`, 1000, digit-advance rate; `DIV = SYS_CLK_HZ/SCAN_HZ` cycles per digit, must be ≥ 4.
- `GUARD_CYC`, 16, cycles per digit slot with all commons off; must satisfy `GUARD_CYC < DIV`.
- `BLINK_HZ`, 2, blink frequency (used only with `FND_BLINK_EN`).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit_data`  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- `blank_lz`  in  1  1 = blank leading zeros.
- `blink`  in  1  1 = blink whole display (ignored without `FND_BLINK_EN`).
- `bcd`  out  4  code to segment decoder; 4'hF = blank.
- `fnd_comm`  out  4  active-low digit commons, one-hot-low or 4'hF.
- `scan_tick`  out  1  one-cycle pulse at each digit advance.

## Operation
- **Scan counter `scan_cnt`**
  - Range 0..DIV-1, increments every cycle, wraps DIV-1 → 0.
  - Internal tick is true when `scan_cnt == DIV-1`.
- **Digit selector `digit_sel`**
  - 2 bits, increments on tick, wraps 3 → 0.
- **Output stage (registered every cycle from current internal state)**
  - `fnd_comm` = 4'hF if `scan_cnt < GUARD_CYC` or the blink-off phase is active. Otherwise it is `~(4'b0001 << digit_sel)`.
  - `bcd` = 4'hF if the selected digit is blanked. Otherwise it is the nibble of `digit_data` selected by `digit_sel`.
  - `scan_tick` = registered internal tick.
- **Leading-zero blanking** (only when `blank_lz` = 1)
  - Digit 3 is blanked if d3 == 0.
  - Digit 2 is blanked if d3 == 0 and d2 == 0.
  - Digit 1 is blanked if d3, d2 and d1 are all 0.
  - Digit 0 is never blanked, so all-zero input shows "0".
  - Nibbles A–F count as nonzero and pass through unchanged.
- **Input sampling**
  - `digit_data`, `blank_lz` and `blink` are sampled every cycle with no hold requirement.
  - A change mid-slot appears on `bcd` in the next cycle.
- **Reset values**
  - `scan_cnt` = 0, `digit_sel` = 0.
  - `bcd` = 4'hF, `fnd_comm` = 4'hF, `scan_tick` = 0.
  - Blink phase = visible, blink counter = 0.
- **Reset mid-scan**: restarts from digit 0 with the counters cleared. No partial slot is completed.

## Timing
- All outputs lag internal state by exactly 1 cycle. `bcd` and `fnd_comm` always change on the same edge.
- **First slot after reset deassertion**
  - `fnd_comm` = 4'hF for cycles 1..GUARD_CYC.
  - Digit 0 is enabled from cycle GUARD_CYC+1.
  - The first `scan_tick` is high on cycle DIV.
- **Steady state**
  - Each digit is lit for `DIV-GUARD_CYC` cycles per `4*DIV`-cycle frame.
  - `scan_tick` has period DIV and width 1.
- **Blink**
  - The phase toggles every `SYS_CLK_HZ/(2*BLINK_HZ)` cycles, independent of the scan.
  - Deasserting `blink` restores commons on the next cycle.
  - Asserting `blink` takes effect only during the off phase.

## Configuration
- **`FND_BLINK_EN` defined**: blink counter and phase flop are present, and `blink` gates `fnd_comm` as above.
- **`FND_BLINK_EN` undefined**: no blink logic. `blink` is unused, and `fnd_comm` depends only on the guard time and `digit_sel`.

## Structure
- **Shared package/header `fnd_pkg`** holds:
  - `FND_BCD_BLANK` = 4'hF
  - `FND_BCD_DOT` = 4'hE
  - `FND_COMM_OFF` = 4'hF
  - The digit-index width.
- **Sub-module `fnd_tick_gen`**: parameterised modulo-N counter with wrap pulse. It is instantiated once for the scan, and once more for blink under `FND_BLINK_EN`.

## Test plan
All scenarios use SYS_CLK_HZ=1000, SCAN_HZ=100 (DIV=10), GUARD_CYC=2, BLINK_HZ=25 (half-period 20).
- **Reset**: hold `reset` for 3 cycles, then release with `digit_data`=16'h1234 → `fnd_comm`=4'hF and `bcd`=4'hF during reset. `fnd_comm`=4'hE and `bcd`=4'h4 from cycle 3. First `scan_tick` at cycle 10.
- **Scan order**: `digit_data`=16'h1234, run 40 cycles → lit digits in order 0,1,2,3 show `bcd` 4,3,2,1. `fnd_comm` = E,D,B,7, each lit for 8 cycles after 2 off cycles, then wraps to digit 0.
- **Leading-zero blanking**: `digit_data`=16'h0050 with `blank_lz`=1 → digits 3 and 2 give `bcd`=4'hF, digit 1 gives 5, digit 0 gives 0. `digit_data`=16'h0000 → only digit 0 shows 0. With `blank_lz`=0 → all digits show 0.
- **Non-decimal nibble**: `digit_data`=16'h0A00 with `blank_lz`=1 → digit 3 is blank. Digits 2, 1 and 0 show A, 0 and 0 (not blanked).
- **Blink** (`FND_BLINK_EN` defined): `blink`=1 → `fnd_comm`=4'hF for 20 cycles, then normal scan for 20 cycles, repeating. With the macro undefined, the same stimulus gives an unchanged scan.
- **Reset mid-scan**: assert `reset` while `digit_sel`=2 → next cycle `fnd_comm`=4'hF and `bcd`=4'hF. After release, the scan restarts at digit 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared codes, widths and helpers for the FND scan controller.
// Revision: 1.0
`default_nettype none

package fnd_pkg;

    localparam int          FND_DIGIT_W   = 2;
    localparam logic [3:0]  FND_BCD_BLANK = 4'hF;
    localparam logic [3:0]  FND_BCD_DOT   = 4'hE;
    localparam logic [3:0]  FND_COMM_OFF  = 4'hF;

    typedef logic [FND_DIGIT_W-1:0] fnd_digit_t;

    // Active-low common for a single selected digit.
    function automatic logic [3:0] fnd_comm_sel(input fnd_digit_t sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_tick_gen.sv
// fnd_tick_gen: modulo-N free-running counter with a wrap pulse on count N-1.
// Revision: 1.0
`default_nettype none

module fnd_tick_gen #(
    parameter int N = 10,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

endmodule

`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: four-digit multiplexed FND scan with leading-zero blanking and guard time.
// Optional blink enabled by defining FND_BLINK_EN. Revision: 1.0
`default_nettype none

module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int GUARD_CYC  = 16,
    parameter int BLINK_HZ   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digit_data,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [3:0]  bcd,
    output logic [3:0]  fnd_comm,
    output logic        scan_tick
);

    localparam int DIV = SYS_CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] w_scan_cnt;
    logic          w_tick;
    fnd_digit_t    r_digit_sel;
    logic [3:0]    w_blank;
    logic [3:0]    w_nibble;
    logic          w_in_guard;
    logic          w_blink_gate;
    logic [3:0]    r_bcd;
    logic [3:0]    r_comm;
    logic          r_tick;

    fnd_tick_gen #(
        .N (DIV),
        .W (CW)
    ) u_scan (
        .clk    (clk),
        .rst    (reset),
        .o_cnt  (w_scan_cnt),
        .o_wrap (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit_sel <= '0;
        end else if (w_tick) begin
            r_digit_sel <= r_digit_sel + 1'b1;
        end
    end

`ifdef FND_BLINK_EN
    localparam int BLINK_HALF = SYS_CLK_HZ / (2 * BLINK_HZ);
    localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] w_unused_blink_cnt;
    logic          w_blink_wrap;
    logic          r_blink_off;

    fnd_tick_gen #(
        .N (BLINK_HALF),
        .W (BW)
    ) u_blink (
        .clk    (clk),
        .rst    (reset),
        .o_cnt  (w_unused_blink_cnt),
        .o_wrap (w_blink_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_off <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_off <= ~r_blink_off;
        end
    end

    // Phase runs freely; the blink input only masks commons while in the off phase.
    assign w_blink_gate = blink & r_blink_off;
`else
    logic w_unused_blink;

    assign w_unused_blink = blink ^ (BLINK_HZ == 0);
    assign w_blink_gate   = 1'b0;
`endif

    // A digit is blanked only when it and every more significant digit are zero.
    assign w_blank[3] = blank_lz & (digit_data[15:12] == 4'h0);
    assign w_blank[2] = w_blank[3] & (digit_data[11:8] == 4'h0);
    assign w_blank[1] = w_blank[2] & (digit_data[7:4] == 4'h0);
    assign w_blank[0] = 1'b0;

    assign w_nibble   = digit_data[{r_digit_sel, 2'b00} +: 4];
    assign w_in_guard = (w_scan_cnt < CW'(GUARD_CYC));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd  <= FND_BCD_BLANK;
            r_comm <= FND_COMM_OFF;
            r_tick <= 1'b0;
        end else begin
            r_bcd  <= w_blank[r_digit_sel] ? FND_BCD_BLANK : w_nibble;
            r_comm <= (w_in_guard || w_blink_gate) ? FND_COMM_OFF
                                                   : fnd_comm_sel(r_digit_sel);
            r_tick <= w_tick;
        end
    end

    assign bcd       = r_bcd;
    assign fnd_comm  = r_comm;
    assign scan_tick = r_tick;

endmodule

`default_nettype wire
